// File: rtl/bit_flip_injector.sv
// ---------------------------------------------------------------------------
// BitFlipInjector
//
// Purpose:
//    Streaming fault injector. Each accepted word may be corrupted according
//    to a pseudo-random decision taken from a 16-bit Fibonacci LFSR. A single
//    output register stage gives one cycle of latency. The stage supports
//    full throughput and applies backpressure through in_ready.
//
// Ports:
//    clk          sole clock, all state updates on the rising edge
//    reset        synchronous, active-high reset
//    in_valid     upstream word present
//    in_ready     block accepts a word this cycle (combinational)
//    in_data      upstream word, W bits
//    out_valid    out_data holds a word
//    out_ready    downstream accepts the held word
//    out_data     processed word, W bits
//    out_faulted  out_data was corrupted
//    mode         00 pass, 01 single flip, 10 double flip, 11 stuck-at-0
//    threshold    injection rate, 0 never, 256 or more always
//    seed_load    one-cycle pulse that loads seed into the LFSR
//    seed         LFSR seed, 0 is replaced by 16'hACE1
//    fault_count  saturating count of corrupted words delivered downstream
// ---------------------------------------------------------------------------
module bit_flip_injector #(
    parameter int          W    = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_faulted,
    input  logic [1:0]   mode,
    input  logic [8:0]   threshold,
    input  logic         seed_load,
    input  logic [15:0]  seed,
    output logic [15:0]  fault_count
);

    // Position field width and one-bit-wider helpers, so that comparisons
    // against W never overflow when W is a power of two.
    localparam int          P          = $clog2(W);
    localparam int          PW         = P + 1;
    localparam logic [PW-1:0] W_EXT    = PW'(W);
    localparam logic [PW-1:0] LAST_POS = PW'(W - 1);

    // An all-zero LFSR would lock up, so zero seeds are replaced.
    localparam logic [15:0] FALLBACK_SEED = 16'hACE1;
    localparam logic [15:0] RESET_SEED    = (SEED == 16'h0000) ? FALLBACK_SEED : SEED;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_DOUBLE = 2'b10;
    localparam logic [1:0] MODE_STUCK0 = 2'b11;

    // Registered state with next-state companions
    logic [15:0]  lfsr_q, lfsr_d;
    logic         outValid_q, outValid_d;
    logic [W-1:0] outData_q, outData_d;
    logic         outFaulted_q, outFaulted_d;
    logic [15:0]  faultCount_q, faultCount_d;

    // Combinational datapath signals
    logic          accept;
    logic          transfer;
    logic          inject;
    logic          feedback;
    logic [PW-1:0] fWide;
    logic [PW-1:0] posAWide;
    logic [PW-1:0] posBWide;
    logic [P-1:0]  posA;
    logic [P-1:0]  posB;
    logic [W-1:0]  maskA;
    logic [W-1:0]  maskB;
    logic [W-1:0]  corrupted;
    logic [15:0]  seedEffective;

    // The stage can take a new word whenever it is empty or its current
    // word leaves this same cycle, which gives back-to-back throughput.
    assign in_ready = !outValid_q || out_ready;

    assign accept   = in_valid && in_ready;
    assign transfer = outValid_q && out_ready;

    // Work out where to corrupt the incoming word. Everything here uses the
    // LFSR value from before this cycle's advance, so the decision for a word
    // depends only on how many words were accepted before it. The position
    // field can exceed W-1 when W is not a power of two. Folding it back by
    // subtracting W always lands in range because the field is below 2*W.
    always_comb begin
        fWide    = {1'b0, lfsr_q[8+P-1:8]};
        posAWide = (fWide >= W_EXT) ? (fWide - W_EXT) : fWide;
        posA     = posAWide[P-1:0];
        posBWide = ({1'b0, posA} < LAST_POS) ? ({1'b0, posA} + PW'(1)) : '0;
        posB     = posBWide[P-1:0];
        maskA    = {{(W-1){1'b0}}, 1'b1} << posA;
        maskB    = {{(W-1){1'b0}}, 1'b1} << posB;
        inject   = (mode != MODE_PASS) && ({1'b0, lfsr_q[7:0]} < threshold);
    end

    // Apply the selected corruption. Stuck-at-0 on a bit that is already
    // clear leaves the data unchanged, but the word still counts as faulted.
    always_comb begin
        corrupted = in_data;
        if (inject) begin
            case (mode)
                MODE_SINGLE: corrupted = in_data ^ maskA;
                MODE_DOUBLE: corrupted = in_data ^ maskA ^ maskB;
                MODE_STUCK0: corrupted = in_data & ~maskA;
                default:     corrupted = in_data;
            endcase
        end
    end

    // LFSR next state. The LFSR shifts left and feeds taps 15, 13, 12 and 10
    // into bit 0. It moves only when a word is accepted, so a stalled stream
    // keeps its random sequence. A seed load takes priority over the advance.
    always_comb begin
        feedback      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        seedEffective = (seed == 16'h0000) ? FALLBACK_SEED : seed;
        lfsr_d        = lfsr_q;
        if (seed_load) begin
            lfsr_d = seedEffective;
        end else if (accept) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    // Output stage next state. A new word replaces the held word, including
    // when the held word drains in the same cycle. Otherwise the stage empties
    // on a transfer, or holds its contents steady while stalled.
    always_comb begin
        outValid_d   = outValid_q;
        outData_d    = outData_q;
        outFaulted_d = outFaulted_q;
        if (accept) begin
            outValid_d   = 1'b1;
            outData_d    = corrupted;
            outFaulted_d = inject;
        end else if (transfer) begin
            outValid_d = 1'b0;
        end
    end

    // The fault counter counts corrupted words when they are handed
    // downstream, not when they are accepted. It stops at all-ones.
    always_comb begin
        faultCount_d = faultCount_q;
        if (transfer && outFaulted_q && (faultCount_q != 16'hFFFF)) begin
            faultCount_d = faultCount_q + 16'd1;
        end
    end

    // State registers. Reset has priority over seed loads and handshakes, and
    // it discards any word that is being held.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= RESET_SEED;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            outFaulted_q <= 1'b0;
            faultCount_q <= 16'h0000;
        end else begin
            lfsr_q       <= lfsr_d;
            outValid_q   <= outValid_d;
            outData_q    <= outData_d;
            outFaulted_q <= outFaulted_d;
            faultCount_q <= faultCount_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign out_faulted = outFaulted_q;
    assign fault_count = faultCount_q;

endmodule

// File: tb/tb_bit_flip_injector.sv
// ---------------------------------------------------------------------------
// TbBitFlipInjector
//
// Purpose:
//    Scoreboard bench for bit_flip_injector. Drives a W=16 instance with
//    randomized traffic and a W=12 instance with folded-position cases. A
//    behavioural model predicts each word when it is accepted. Independent
//    monitors compare the words when they leave the design.
// ---------------------------------------------------------------------------
module tb_bit_flip_injector;

    localparam logic [15:0] SEED16 = 16'hACE1;
    localparam logic [15:0] SEED12 = 16'h1D2B;

    typedef struct {
        logic [31:0] data;
        logic        faulted;
    } expT;

    // Clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=16 instance signals
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = '0;
    logic        out_ready = 1'b0;
    logic [1:0]  mode      = '0;
    logic [8:0]  threshold = '0;
    logic        seed_load = 1'b0;
    logic [15:0] seed      = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_faulted;
    logic [15:0] fault_count;

    // W=12 instance signals
    logic        reset12     = 1'b1;
    logic        in_valid12  = 1'b0;
    logic [11:0] in_data12   = '0;
    logic        out_ready12 = 1'b1;
    logic [1:0]  mode12      = '0;
    logic [8:0]  threshold12 = '0;
    logic        seed_load12 = 1'b0;
    logic [15:0] seed12      = '0;
    logic        in_ready12;
    logic        out_valid12;
    logic [11:0] out_data12;
    logic        out_faulted12;
    logic [15:0] fault_count12;

    bit_flip_injector #(.W(16), .SEED(SEED16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_faulted(out_faulted), .mode(mode),
        .threshold(threshold), .seed_load(seed_load), .seed(seed),
        .fault_count(fault_count)
    );

    bit_flip_injector #(.W(12), .SEED(SEED12)) dut12 (
        .clk(clk), .reset(reset12), .in_valid(in_valid12), .in_ready(in_ready12),
        .in_data(in_data12), .out_valid(out_valid12), .out_ready(out_ready12),
        .out_data(out_data12), .out_faulted(out_faulted12), .mode(mode12),
        .threshold(threshold12), .seed_load(seed_load12), .seed(seed12),
        .fault_count(fault_count12)
    );

    int checks   = 0;
    int failures = 0;

    // Model state for the W=16 instance
    logic [15:0] mLfsr     = SEED16;
    bit          mOcc      = 1'b0;
    int          mCount    = 0;
    bit          expValid  = 1'b0;
    bit          expReady  = 1'b1;
    bit          expZero   = 1'b0;
    bit          prevRst   = 1'b0;
    expT         sbQ[$];

    // Model state for the W=12 instance
    logic [15:0] m12Lfsr   = SEED12;
    int          m12Count  = 0;
    bit          exp12Valid = 1'b0;
    bit          done12    = 1'b0;
    expT         q12[$];

    // Compare and report one value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // The LFSR is modelled as an integer recurrence: double the value, add
    // the parity of taps 15, 13, 12 and 10, and keep 16 bits.
    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        int v;
        int fb;
        v  = l;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v * 2) + fb) % 65536);
    endfunction

    // The expected output word, taken from the injection rules
    function automatic expT refWord(input logic [31:0] d, input logic [1:0] md,
                                    input logic [8:0] thr, input logic [15:0] l,
                                    input int width);
        expT r;
        int  p;
        int  lv;
        int  f;
        int  a;
        int  b;
        logic [31:0] bitA;
        logic [31:0] bitB;
        p = 0;
        while ((1 << p) < width) p++;
        lv = l;
        f  = (lv / 256) % (1 << p);
        a  = (f >= width) ? f - width : f;
        b  = (a + 1) % width;
        bitA = 32'd1 << a;
        bitB = 32'd1 << b;
        r.faulted = (md != 2'd0) && ((lv % 256) < int'(thr));
        r.data    = d;
        if (r.faulted) begin
            case (md)
                2'd1:    r.data = d ^ bitA;
                2'd2:    r.data = d ^ bitA ^ bitB;
                default: r.data = d & ~bitA;
            endcase
        end
        return r;
    endfunction

    // Drive one cycle on the W=16 instance and advance the model
    task automatic applyStimulus(input bit rst, input bit vld, input logic [15:0] d,
                                 input logic [1:0] md, input logic [8:0] thr,
                                 input bit ordy, input bit sl, input logic [15:0] sd);
        bit acc;
        @(posedge clk);
        #1;
        reset = rst; in_valid = vld; in_data = d; mode = md; threshold = thr;
        out_ready = ordy; seed_load = sl; seed = sd;
        expZero  = prevRst;
        prevRst  = rst;
        expValid = mOcc;
        expReady = !mOcc || ordy;
        if (rst) begin
            mOcc   = 1'b0;
            mLfsr  = SEED16;
            mCount = 0;
            sbQ.delete();
        end else begin
            acc = vld && expReady;
            if (acc) sbQ.push_back(refWord(32'(d), md, thr, mLfsr, 16));
            if (sl) mLfsr = (sd == 16'h0) ? 16'hACE1 : sd;
            else if (acc) mLfsr = lfsrStep(mLfsr);
            mOcc = acc ? 1'b1 : (ordy ? 1'b0 : mOcc);
        end
    endtask

    // Drive one cycle on the W=12 instance. out_ready stays high there, so
    // every valid word is accepted. The expectation is either supplied
    // directly or taken from the model.
    task automatic drive12(input bit rst, input bit vld, input logic [11:0] d,
                           input logic [1:0] md, input logic [8:0] thr,
                           input bit sl, input logic [15:0] sd,
                           input bit useConst, input logic [31:0] cData);
        expT e;
        @(posedge clk);
        #1;
        reset12 = rst; in_valid12 = vld; in_data12 = d; mode12 = md;
        threshold12 = thr; seed_load12 = sl; seed12 = sd;
        if (rst) begin
            m12Lfsr    = SEED12;
            m12Count   = 0;
            exp12Valid = 1'b0;
            q12.delete();
        end else begin
            if (vld) begin
                e = refWord(32'(d), md, thr, m12Lfsr, 12);
                if (useConst) begin
                    e.data    = cData;
                    e.faulted = 1'b1;
                end
                q12.push_back(e);
            end
            if (sl) m12Lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
            else if (vld) m12Lfsr = lfsrStep(m12Lfsr);
        end
    endtask

    // Monitor for the W=16 instance. It checks the handshake and the counter
    // against the model. It pops a word when the model says one is being
    // delivered, and otherwise checks that a stalled word holds steady.
    always @(negedge clk) begin
        expT e;
        if (!reset) begin
            checkOutput("in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("out_valid", 32'(out_valid), 32'(expValid));
            checkOutput("fault_count", 32'(fault_count), 32'(mCount));
            if (expZero) begin
                checkOutput("reset_out_data", 32'(out_data), 32'h0);
                checkOutput("reset_out_faulted", 32'(out_faulted), 32'h0);
            end
            if (expValid) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard_empty actual=%0d required=1", sbQ.size());
                end else if (out_ready) begin
                    e = sbQ.pop_front();
                    checkOutput("out_data", 32'(out_data), e.data);
                    checkOutput("out_faulted", 32'(out_faulted), 32'(e.faulted));
                    if (e.faulted && mCount < 65535) mCount++;
                end else begin
                    checkOutput("hold_out_data", 32'(out_data), sbQ[0].data);
                    checkOutput("hold_out_faulted", 32'(out_faulted), 32'(sbQ[0].faulted));
                end
            end
        end
    end

    // Monitor for the W=12 instance
    always @(negedge clk) begin
        expT e;
        if (!reset12) begin
            checkOutput("w12_in_ready", 32'(in_ready12), 32'h1);
            checkOutput("w12_fault_count", 32'(fault_count12), 32'(m12Count));
            if (out_valid12) begin
                if (q12.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL w12_unexpected_output actual=%h required=none", out_data12);
                end else begin
                    e = q12.pop_front();
                    checkOutput("w12_out_data", 32'(out_data12), e.data);
                    checkOutput("w12_out_faulted", 32'(out_faulted12), 32'(e.faulted));
                    if (e.faulted && m12Count < 65535) m12Count++;
                end
            end
        end
    end

    // Folded position cases for W=12. A seed with bits 11:8 = 15 folds to
    // pos_a=3, pos_b=4. A seed with bits 11:8 = 11 gives pos_a=11 and pos_b
    // wraps to 0. Random words then follow.
    initial begin
        drive12(1, 0, '0, 2'd0, 9'd0, 0, 16'h0, 0, 32'h0);
        drive12(1, 0, '0, 2'd0, 9'd0, 0, 16'h0, 0, 32'h0);
        drive12(0, 0, '0, 2'd0, 9'd0, 1, 16'h0F00, 0, 32'h0);
        drive12(0, 1, 12'h000, 2'd2, 9'd256, 0, 16'h0, 1, 32'h018);
        drive12(0, 0, '0, 2'd0, 9'd0, 1, 16'h0B00, 0, 32'h0);
        drive12(0, 1, 12'h000, 2'd2, 9'd256, 0, 16'h0, 1, 32'h801);
        for (int i = 0; i < 60; i++) begin
            drive12(0, $urandom_range(0, 3) != 0, 12'($urandom), 2'($urandom_range(0, 3)),
                    9'($urandom_range(0, 300)), $urandom_range(0, 15) == 0,
                    16'($urandom), 0, 32'h0);
        end
        drive12(0, 0, '0, 2'd0, 9'd0, 0, 16'h0, 0, 32'h0);
        drive12(0, 0, '0, 2'd0, 9'd0, 0, 16'h0, 0, 32'h0);
        done12 = 1'b1;
    end

    // Main sequence for the W=16 instance
    initial begin
        applyStimulus(1, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);
        applyStimulus(1, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);

        // A forced single flip straight after reset
        applyStimulus(0, 1, 16'h0000, 2'd1, 9'd256, 1, 0, 16'h0);
        applyStimulus(0, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);
        applyStimulus(0, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);

        // A zero threshold never corrupts, whatever the mode or backpressure
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(0, 1, 16'($urandom), 2'($urandom_range(0, 3)), 9'd0,
                          $urandom_range(0, 3) != 0, 0, 16'h0);
        end

        // Fully random traffic, with occasional reseeds that include zero
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(0, $urandom_range(0, 3) != 0, 16'($urandom),
                          2'($urandom_range(0, 3)), 9'($urandom_range(0, 300)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                          ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end

        // Stall for five cycles with a word pending, then release with no gap
        applyStimulus(0, 1, 16'h1234, 2'd1, 9'd128, 1, 0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 16'($urandom), 2'd2, 9'd200, 0, 0, 16'h0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 16'($urandom), 2'd3, 9'd200, 1, 0, 16'h0);
        end

        // A zero seed behaves as 16'hACE1, applied twice with identical traffic
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(0, 0, '0, 2'd0, 9'd0, 1, 1, 16'h0);
            for (int i = 0; i < 20; i++) begin
                applyStimulus(0, 1, 16'(i * 16'h0F1F), 2'd1 + 2'(i % 3), 9'd180, 1, 0, 16'h0);
            end
        end

        // Reset beats a seed load and a handshake, and drops the held word
        applyStimulus(0, 1, 16'hBEEF, 2'd1, 9'd256, 0, 0, 16'h0);
        applyStimulus(1, 1, 16'hCAFE, 2'd1, 9'd256, 1, 1, 16'h1234);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 16'($urandom), 2'd2, 9'd300, 1, 0, 16'h0);
        end

        // Saturate the fault counter, then reset in mid-stream
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(0, 1, 16'($urandom), 2'd1, 9'd256, 1, 0, 16'h0);
        end
        applyStimulus(1, 1, 16'h5555, 2'd1, 9'd256, 1, 0, 16'h0);
        applyStimulus(0, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);
        applyStimulus(0, 1, 16'h00F0, 2'd3, 9'd256, 1, 0, 16'h0);
        applyStimulus(0, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);
        applyStimulus(0, 0, '0, 2'd0, 9'd0, 1, 0, 16'h0);

        // Everything predicted must have been delivered
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
        for (int i = 0; i < 1000 && !done12; i++) @(negedge clk);
        checkOutput("w12_finished", 32'(done12), 32'h1);
        checkOutput("w12_scoreboard_drained", 32'(q12.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
